// File: rtl/iss_if.sv
// Issue handshake between Decode and the scoreboard: valid/ready plus operand and destination fields.
// Latency: none, this is wiring only.
// Backpressure: Decode holds every field stable while iss_valid=1 and iss_ready=0.
interface iss_if;
    logic       iss_valid;
    logic       iss_ready;
    logic [4:0] iss_rs1;
    logic [4:0] iss_rs2;
    logic       iss_use_rs1;
    logic       iss_use_rs2;
    logic [4:0] iss_rd;
    logic       iss_we;
    logic       iss_fu;     // 0 = ALU, 1 = LSU

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2, iss_rd, iss_we, iss_fu,
        input  iss_ready
    );
    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2, iss_rd, iss_we, iss_fu,
        output iss_ready
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks pending writes (RAW/WAW), LSU occupancy and the single wb port.
// Latency: fire at cycle T gives wb_valid_o at T+ALU_LAT (ALU) or T+LSU_LAT (LSU); starts are same-cycle.
// Backpressure: iss_ready is combinational from hazards only, independent of iss_valid; 0 during reset.
// Ports: clk_i, rst_ni (sync, active-low), iss (iss_if.slave), alu_start_o, lsu_start_o,
//        wb_valid_o, wb_rd_o, wb_fu_o, pending_o[31:0].
// Option: define SB_BYPASS_EN to let a consumer issue in the same cycle its producer writes back.
module issue_scoreboard #(
    parameter int ALU_LAT = 1,   // 1..6, pipelined
    parameter int LSU_LAT = 3    // ALU_LAT < LSU_LAT <= 7, non-pipelined
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    iss_if.slave        iss,
    output logic        alu_start_o,
    output logic        lsu_start_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_fu_o,
    output logic [31:0] pending_o
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [2:0] LSU_CNT0 = 3'(LSU_LAT - 1);

    // Writeback reservation table; slot 1 is the one writing back this cycle.
    logic [7:1] slot_v_q,  slot_v_d;
    logic [7:1] slot_fu_q, slot_fu_d;
    logic [4:0] slot_rd_q [1:7];
    logic [4:0] slot_rd_d [1:7];
    logic [8:1] slot_v_ext;         // slot 8 is an always-empty pad so L+1 is in range for L=7

    logic [31:0] pending_q, pending_d;
    logic [0:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [31:0] busy_vec;
    logic        raw, waw, wbc, lsb, fire, alloc;

    assign slot_v_ext = {1'b0, slot_v_q};

    assign wb_valid_o = rst_ni & slot_v_q[1];
    assign wb_rd_o    = rst_ni ? slot_rd_q[1] : 5'd0;
    assign wb_fu_o    = rst_ni & slot_fu_q[1];
    assign pending_o  = pending_q;

    always_comb begin
        busy_vec = pending_q;
`ifdef SB_BYPASS_EN
        // The register written back this cycle is readable via ARF write-through.
        if (wb_valid_o) busy_vec[wb_rd_o] = 1'b0;
`endif
        busy_vec[0] = 1'b0;
    end

    assign raw = (iss.iss_use_rs1 & busy_vec[iss.iss_rs1]) | (iss.iss_use_rs2 & busy_vec[iss.iss_rs2]);
    assign waw = iss.iss_we & busy_vec[iss.iss_rd];
    // The occupant of slot L+1 shifts into slot L next edge, so our writeback cycle is taken.
    assign wbc = iss.iss_we & (iss.iss_fu ? slot_v_ext[LSU_LAT + 1] : slot_v_ext[ALU_LAT + 1]);
    assign lsb = iss.iss_fu & (state_q == ST_BUSY);

    assign iss.iss_ready = rst_ni & ~raw & ~waw & ~wbc & ~lsb;
    assign fire          = iss.iss_valid & iss.iss_ready;
    assign alloc         = fire & iss.iss_we & (iss.iss_rd != 5'd0);
    assign alu_start_o   = fire & ~iss.iss_fu;
    assign lsu_start_o   = fire & iss.iss_fu;

    always_comb begin
        for (int i = 1; i < 7; i++) begin
            slot_v_d[i]  = slot_v_q[i + 1];
            slot_fu_d[i] = slot_fu_q[i + 1];
            slot_rd_d[i] = slot_rd_q[i + 1];
        end
        slot_v_d[7]  = 1'b0;
        slot_fu_d[7] = 1'b0;
        slot_rd_d[7] = 5'd0;
        if (alloc) begin
            if (iss.iss_fu) begin
                slot_v_d[LSU_LAT]  = 1'b1;
                slot_fu_d[LSU_LAT] = 1'b1;
                slot_rd_d[LSU_LAT] = iss.iss_rd;
            end else begin
                slot_v_d[ALU_LAT]  = 1'b1;
                slot_fu_d[ALU_LAT] = 1'b0;
                slot_rd_d[ALU_LAT] = iss.iss_rd;
            end
        end
    end

    // Clear first, then set, so a same-edge set of the retiring register wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid_o) pending_d[wb_rd_o] = 1'b0;
        if (alloc)      pending_d[iss.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (lsu_start_o) begin
                state_d = ST_BUSY;
                cnt_d   = LSU_CNT0;
            end
        end else begin
            if (cnt_q == 3'd1) state_d = ST_IDLE;
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_v_q  <= '0;
            slot_fu_q <= '0;
            for (int i = 1; i <= 7; i++) slot_rd_q[i] <= 5'd0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
        end else begin
            slot_v_q  <= slot_v_d;
            slot_fu_q <= slot_fu_d;
            for (int i = 1; i <= 7; i++) slot_rd_q[i] <= slot_rd_d[i];
            pending_q <= pending_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard at ALU_LAT=1, LSU_LAT=3.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
// Expected values follow SB_BYPASS_EN when the bench is built with it defined.
module tb_issue_scoreboard;
    logic        clk;
    logic        rst_n;
    logic        alu_start, lsu_start, wb_valid, wb_fu;
    logic [4:0]  wb_rd;
    logic [31:0] pending;
    int          n_vec;
    int          n_bad;

    iss_if u_if ();

    issue_scoreboard #(.ALU_LAT(1), .LSU_LAT(3)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .iss         (u_if),
        .alu_start_o (alu_start),
        .lsu_start_o (lsu_start),
        .wb_valid_o  (wb_valid),
        .wb_rd_o     (wb_rd),
        .wb_fu_o     (wb_fu),
        .pending_o   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic idle;
        u_if.iss_valid   = 1'b0;
        u_if.iss_rs1     = 5'd0;
        u_if.iss_rs2     = 5'd0;
        u_if.iss_use_rs1 = 1'b0;
        u_if.iss_use_rs2 = 1'b0;
        u_if.iss_rd      = 5'd0;
        u_if.iss_we      = 1'b0;
        u_if.iss_fu      = 1'b0;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic [4:0] rd, input logic we, input logic fu);
        u_if.iss_valid   = 1'b1;
        u_if.iss_rs1     = rs1;
        u_if.iss_rs2     = rs2;
        u_if.iss_use_rs1 = u1;
        u_if.iss_use_rs2 = u2;
        u_if.iss_rd      = rd;
        u_if.iss_we      = we;
        u_if.iss_fu      = fu;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0;
        // Reset: instruction presented but nothing may be accepted or written back.
        present(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
        settle();
        check("rst_ready", 32'(u_if.iss_ready), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        check("rst_pending", pending, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("post_rst_ready", 32'(u_if.iss_ready), 32'd1);

        // addi x2: start now, writeback next cycle, pending only during that cycle.
        tick();
        present(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
        settle();
        check("addi_ready", 32'(u_if.iss_ready), 32'd1);
        check("addi_alu_start", 32'(alu_start), 32'd1);
        check("addi_lsu_start", 32'(lsu_start), 32'd0);
        tick();
        idle();
        settle();
        check("addi_wb_valid", 32'(wb_valid), 32'd1);
        check("addi_wb_rd", 32'(wb_rd), 32'd2);
        check("addi_wb_fu", 32'(wb_fu), 32'd0);
        check("addi_pending", pending, 32'h0000_0004);
        tick();
        settle();
        check("addi_pending_clr", pending, 32'd0);
        check("addi_wb_done", 32'(wb_valid), 32'd0);
        drain(2);

        // lw x5 then add x6,x5,x5 presented at cycle 1 (RAW).
        present(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        settle();
        check("lw_lsu_start", 32'(lsu_start), 32'd1);
        tick();
        present(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        check("raw_stall1", 32'(u_if.iss_ready), 32'd0);
        check("raw_pending", pending, 32'h0000_0020);
        tick();
        settle();
        check("raw_stall2", 32'(u_if.iss_ready), 32'd0);
        tick();
        settle();
        check("lw_wb_valid", 32'(wb_valid), 32'd1);
        check("lw_wb_rd", 32'(wb_rd), 32'd5);
        check("lw_wb_fu", 32'(wb_fu), 32'd1);
`ifdef SB_BYPASS_EN
        check("raw_bypass_ready", 32'(u_if.iss_ready), 32'd1);
        check("raw_bypass_start", 32'(alu_start), 32'd1);
        tick();
        idle();
        settle();
`else
        check("raw_stall3", 32'(u_if.iss_ready), 32'd0);
        tick();
        settle();
        check("raw_ready", 32'(u_if.iss_ready), 32'd1);
        check("raw_start", 32'(alu_start), 32'd1);
        tick();
        idle();
        settle();
`endif
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_wb_rd", 32'(wb_rd), 32'd6);
        drain(3);

        // lw x5 then addi x7 at cycle 2: writeback-port conflict.
        present(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        settle();
        check("wbc_lw_start", 32'(lsu_start), 32'd1);
        tick();
        idle();
        tick();
        present(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        settle();
        check("wbc_stall", 32'(u_if.iss_ready), 32'd0);
        tick();
        settle();
        check("wbc_ready", 32'(u_if.iss_ready), 32'd1);
        check("wbc_wb_rd5", 32'(wb_rd), 32'd5);
        tick();
        idle();
        settle();
        check("wbc_wb_valid7", 32'(wb_valid), 32'd1);
        check("wbc_wb_rd7", 32'(wb_rd), 32'd7);
        check("wbc_wb_fu7", 32'(wb_fu), 32'd0);
        drain(3);

        // sw, sw back to back: LSU occupancy, no writeback, no pending.
        present(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
        settle();
        check("sw0_start", 32'(lsu_start), 32'd1);
        tick();
        settle();
        check("sw1_stall_c1", 32'(u_if.iss_ready), 32'd0);
        check("sw_no_wb_c1", 32'(wb_valid), 32'd0);
        check("sw_pending", pending, 32'd0);
        tick();
        settle();
        check("sw1_stall_c2", 32'(u_if.iss_ready), 32'd0);
        tick();
        settle();
        check("sw1_start", 32'(lsu_start), 32'd1);
        check("sw_no_wb_c3", 32'(wb_valid), 32'd0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("sw_no_wb_tail", 32'(wb_valid), 32'd0);
            tick();
        end

        // lw x5 then reset at cycle 1: in-flight write discarded.
        present(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        present(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        settle();
        check("mid_rst_ready", 32'(u_if.iss_ready), 32'd0);
        check("mid_rst_start", 32'(alu_start), 32'd0);
        tick();
        settle();
        check("mid_rst_wb_c2", 32'(wb_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        check("mid_rst_wb_c3", 32'(wb_valid), 32'd0);
        check("mid_rst_pending", pending, 32'd0);
        check("mid_rst_addi_fire", 32'(alu_start), 32'd1);
        tick();
        idle();
        settle();
        check("mid_rst_addi_wb", 32'(wb_rd), 32'd5);
        check("mid_rst_addi_fu", 32'(wb_fu), 32'd0);
        drain(3);

        // addi x0 then add x1,x0,x0: x0 is never busy and never written back.
        present(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        settle();
        check("x0_start", 32'(alu_start), 32'd1);
        tick();
        present(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
        settle();
        check("x0_ready", 32'(u_if.iss_ready), 32'd1);
        check("x0_no_wb", 32'(wb_valid), 32'd0);
        check("x0_pending", pending, 32'd0);
        tick();
        idle();
        settle();
        check("x1_wb_rd", 32'(wb_rd), 32'd1);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
